// File: rtl/sar_avg_fifo_if.sv
// Bus between the SAR averager and its neighbours: conversion input, control, FIFO read side.
// master drives conversions and control, slave is the averaging FIFO.
interface sar_avg_fifo_if;
  logic [3:0] code_in;
  logic       conv_done;
  logic       en;
  logic [1:0] avg_sel;
  logic       out_ready;
  logic       clr_ovf;
  logic [3:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_level;
  logic       overflow;

  modport master (
    output code_in, conv_done, en, avg_sel, out_ready, clr_ovf,
    input  out_data, out_valid, fifo_level, overflow
  );

  modport slave (
    input  code_in, conv_done, en, avg_sel, out_ready, clr_ovf,
    output out_data, out_valid, fifo_level, overflow
  );
endinterface

// File: rtl/sar_avg_fifo.sv
// Averages 1/2/4/8 SAR codes per window into a 4-entry FIFO; result visible one cycle after window end.
// out_ready pops the head; a result arriving at a full FIFO with no pop is dropped and flags overflow.
module sar_avg_fifo (
  input  logic             clk,
  input  logic             reset,
  sar_avg_fifo_if.slave    bus
);

  logic       conv_done_prev;
  logic [6:0] acc;
  logic [2:0] cnt;
  logic [1:0] win_sel;

  logic [3:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] level;
  logic       overflow_q;

  logic       capture;
  logic [1:0] eff_sel;
  logic [3:0] cnt_next;
  logic       win_end;
  logic [6:0] acc_sum;
  logic [3:0] result;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       push_ok;
  logic       drop;

  // The first capture of a window uses avg_sel directly, since win_sel is only latched at that edge.
  always_comb begin
    capture  = bus.conv_done & ~conv_done_prev & bus.en;
    eff_sel  = (cnt == 3'd0) ? bus.avg_sel : win_sel;
    cnt_next = {1'b0, cnt} + 4'd1;
    win_end  = capture & (cnt_next == (4'd1 << eff_sel));
    acc_sum  = acc + {3'b000, bus.code_in};
    case (eff_sel)
      2'd0:    result = acc_sum[3:0];
      2'd1:    result = acc_sum[4:1];
      2'd2:    result = acc_sum[5:2];
      default: result = acc_sum[6:3];
    endcase
    fifo_full  = (level == 3'd4);
    fifo_empty = (level == 3'd0);
    pop        = ~fifo_empty & bus.out_ready;
    push_ok    = win_end & (~fifo_full | pop);
    drop       = win_end & fifo_full & ~pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_done_prev <= 1'b0;
      acc            <= 7'd0;
      cnt            <= 3'd0;
      win_sel        <= 2'd0;
    end else begin
      conv_done_prev <= bus.conv_done;
      if (!bus.en) begin
        acc <= 7'd0;
        cnt <= 3'd0;
      end else if (capture) begin
        if (cnt == 3'd0)
          win_sel <= bus.avg_sel;
        if (win_end) begin
          acc <= 7'd0;
          cnt <= 3'd0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt_next[2:0];
        end
      end
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      level      <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
      if (drop)
        overflow_q <= 1'b1;
      else if (bus.clr_ovf)
        overflow_q <= 1'b0;
    end
  end

  assign bus.out_valid  = ~fifo_empty;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;
  assign bus.out_data   = fifo_empty ? 4'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_sar_avg_fifo.sv
// Self-checking bench for sar_avg_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_sar_avg_fifo;

  logic clk;
  logic reset;
  sar_avg_fifo_if bus ();

  sar_avg_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: samples of the open window, its length, and the FIFO as a queue.
  int samples[$];
  int win_len;
  int fifo_q[$];
  bit m_prev;
  bit m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    samples.delete();
    fifo_q.delete();
    win_len = 1;
    m_prev  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step();
    bit cap, pop, full, push;
    int sum, res;
    if (reset) begin
      model_reset();
      return;
    end
    cap  = bus.conv_done && !m_prev && bus.en;
    pop  = (fifo_q.size() > 0) && bus.out_ready;
    full = (fifo_q.size() == 4);
    push = 1'b0;
    res  = 0;
    if (!bus.en)
      samples.delete();
    if (cap) begin
      if (samples.size() == 0)
        win_len = 1 << bus.avg_sel;
      samples.push_back(int'(bus.code_in));
      if (samples.size() == win_len) begin
        sum = 0;
        foreach (samples[i]) sum += samples[i];
        res  = sum / win_len;
        push = 1'b1;
        samples.delete();
      end
    end
    if (pop)
      void'(fifo_q.pop_front());
    if (push) begin
      if (full && !pop)
        m_ovf = 1'b1;
      else
        fifo_q.push_back(res);
    end
    if (!(push && full && !pop) && bus.clr_ovf)
      m_ovf = 1'b0;
    m_prev = bus.conv_done;
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(bus.out_valid), 32'(fifo_q.size() > 0));
    check_eq("fifo_level", 32'(bus.fifo_level), 32'(fifo_q.size()));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_eq("out_data", 32'(bus.out_data), (fifo_q.size() > 0) ? 32'(fifo_q[0]) : 32'd0);
  endtask

  // Inputs are always changed 1 time unit after a rising edge; the model steps on the same values.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic pulse(input logic [3:0] code);
    bus.code_in   = code;
    bus.conv_done = 1'b1;
    step();
    bus.conv_done = 1'b0;
    step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_level", 32'(bus.fifo_level), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    check_eq("rst_data", 32'(bus.out_data), 32'd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    reset         = 1'b1;
    bus.code_in   = 4'd0;
    bus.conv_done = 1'b0;
    bus.en        = 1'b1;
    bus.avg_sel   = 2'd0;
    bus.out_ready = 1'b1;
    bus.clr_ovf   = 1'b0;
    #2;
    check_outputs();
    step();
    reset = 1'b0;
    step();

    // Single-sample windows pass straight through.
    bus.avg_sel = 2'd0;
    bus.code_in = 4'h5; bus.conv_done = 1'b1; step();
    check_eq("s1_data5", 32'(bus.out_data), 32'h5);
    bus.conv_done = 1'b0; step();
    bus.code_in = 4'hA; bus.conv_done = 1'b1; step();
    check_eq("s1_dataA", 32'(bus.out_data), 32'hA);
    bus.conv_done = 1'b0; step();

    // Four-sample window: 3+4+6+8 = 21 -> 5.
    bus.out_ready = 1'b0;
    bus.avg_sel   = 2'd2;
    pulse(4'd3); pulse(4'd4); pulse(4'd6);
    check_eq("s2_no_entry", 32'(bus.fifo_level), 32'd0);
    pulse(4'd8);
    check_eq("s2_level", 32'(bus.fifo_level), 32'd1);
    check_eq("s2_avg", 32'(bus.out_data), 32'd5);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

    // Fill, overflow, hold head, clear the flag.
    bus.avg_sel = 2'd0;
    pulse(4'd1); pulse(4'd2); pulse(4'd3); pulse(4'd4);
    check_eq("s3_full", 32'(bus.fifo_level), 32'd4);
    check_eq("s3_no_ovf", 32'(bus.overflow), 32'd0);
    pulse(4'd5);
    check_eq("s3_ovf", 32'(bus.overflow), 32'd1);
    pulse(4'd6);
    check_eq("s3_head", 32'(bus.out_data), 32'd1);
    bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
    check_eq("s3_clr", 32'(bus.overflow), 32'd0);

    // Push and pop together while full.
    bus.code_in = 4'd7; bus.conv_done = 1'b1; bus.out_ready = 1'b1; step();
    check_eq("s4_level", 32'(bus.fifo_level), 32'd4);
    check_eq("s4_ovf", 32'(bus.overflow), 32'd0);
    bus.conv_done = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.out_ready = 1'b0;

    // avg_sel changes mid-window only affect the next window: 1..8 sums to 36 -> 4.
    bus.avg_sel = 2'd3;
    pulse(4'd1); pulse(4'd2); pulse(4'd3);
    bus.avg_sel = 2'd0;
    pulse(4'd4); pulse(4'd5); pulse(4'd6); pulse(4'd7);
    check_eq("s5_open", 32'(bus.fifo_level), 32'd0);
    pulse(4'd8);
    check_eq("s5_avg8", 32'(bus.out_data), 32'd4);
    pulse(4'd9);
    check_eq("s5_single", 32'(bus.fifo_level), 32'd2);

    // Reset mid-window with entries queued, then a held conv_done counts once.
    bus.avg_sel = 2'd2;
    pulse(4'd1); pulse(4'd2);
    apply_reset();
    bus.code_in = 4'hF; bus.conv_done = 1'b1;
    step(); step(); step();
    bus.conv_done = 1'b0; step();
    check_eq("s6_held", 32'(bus.fifo_level), 32'd0);
    pulse(4'hF); pulse(4'hF); pulse(4'hF);
    check_eq("s6_level", 32'(bus.fifo_level), 32'd1);
    check_eq("s6_data", 32'(bus.out_data), 32'hF);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.code_in   = 4'($urandom_range(0, 15));
      bus.conv_done = ($urandom_range(0, 2) != 0);
      bus.en        = ($urandom_range(0, 19) != 0);
      bus.avg_sel   = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) == 0);
      bus.clr_ovf   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0)
        apply_reset();
      else
        step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
